// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: one single-port pixel RAM shared by the VGA read pipeline
// (always first) and a host write port, with frame-phase tracking and fault flags.
module vga_fb_arbiter #(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 600,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 3,
    parameter int STARVE_MAX = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_ready,
    input  logic [11:0]       disp_x,
    input  logic [11:0]       disp_y,
    input  logic              frame_lock,
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] disp_rgb,
    output logic              disp_rgb_valid,
    output logic              frame_start,
    output logic              starve_err,
    output logic              addr_err
);

    localparam logic [1:0] ST_WAIT_SYNC = 2'd0;
    localparam logic [1:0] ST_SCAN      = 2'd1;
    localparam logic [1:0] ST_VBLANK    = 2'd2;

    localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);
    localparam logic [12:0]       X_LIM   = 13'(H_ACTIVE);
    localparam logic [12:0]       Y_LIM   = 13'(V_ACTIVE);
    localparam logic [11:0]       X_LAST  = 12'(H_ACTIVE - 1);
    localparam logic [11:0]       Y_LAST  = 12'(V_ACTIVE - 1);
    localparam logic [ADDR_W:0]   PIX_LIM = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_W  = ADDR_W'(H_ACTIVE);

    logic [1:0]        state_reg, state_next;
    logic              last_px_reg;
    logic              sof, at_last_px;
    logic              disp_in_range, host_in_range, host_fire;
    logic [ADDR_W-1:0] disp_lin;

    logic [CNT_W-1:0]  starve_cnt_reg, starve_cnt_next;
    logic              starve_err_reg, addr_err_reg, frame_start_reg;

    logic              mem_en_reg, mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    // Index 0 = request seen one cycle ago (RAM access cycle), index 1 = RAM data cycle.
    logic [1:0]        disp_vld_pipe_reg, disp_ok_pipe_reg;
    logic [DATA_W-1:0] disp_rgb_reg;
    logic              disp_rgb_valid_reg;

    assign sof           = disp_ready && (disp_x == 12'd0) && (disp_y == 12'd0);
    assign at_last_px    = disp_ready && (disp_x == X_LAST) && (disp_y == Y_LAST);
    assign disp_in_range = ({1'b0, disp_x} < X_LIM) && ({1'b0, disp_y} < Y_LIM);
    assign host_in_range = {1'b0, host_wr_addr} < PIX_LIM;
    assign disp_lin      = ADDR_W'(disp_y) * LINE_W + ADDR_W'(disp_x);

    // Display owns every slot it asks for; frame lock confines the host to vertical blank.
    assign host_wr_ready = ~rst & ~disp_ready & (~frame_lock | (state_reg == ST_VBLANK));
    assign host_fire     = host_wr_valid & host_wr_ready;

    always_comb begin
        state_next = state_reg;
        if (sof) begin
            state_next = ST_SCAN;
        end else if ((state_reg == ST_SCAN) && last_px_reg && !disp_ready) begin
            state_next = ST_VBLANK;
        end
    end

    always_comb begin
        starve_cnt_next = '0;
        if (host_wr_valid && !host_wr_ready) begin
            starve_cnt_next = (starve_cnt_reg == CNT_MAX) ? CNT_MAX : starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= ST_WAIT_SYNC;
            last_px_reg        <= 1'b0;
            frame_start_reg    <= 1'b0;
            starve_cnt_reg     <= '0;
            starve_err_reg     <= 1'b0;
            addr_err_reg       <= 1'b0;
            mem_en_reg         <= 1'b0;
            mem_we_reg         <= 1'b0;
            mem_addr_reg       <= '0;
            mem_wdata_reg      <= '0;
            disp_vld_pipe_reg  <= '0;
            disp_ok_pipe_reg   <= '0;
            disp_rgb_reg       <= '0;
            disp_rgb_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            last_px_reg     <= at_last_px;
            frame_start_reg <= sof;
            starve_cnt_reg  <= starve_cnt_next;
            starve_err_reg  <= starve_err_reg | (starve_cnt_next == CNT_MAX);
            addr_err_reg    <= addr_err_reg
                             | (disp_ready & ~disp_in_range)
                             | (host_fire & ~host_in_range);

            mem_en_reg <= 1'b0;
            mem_we_reg <= 1'b0;
            if (disp_ready) begin
                mem_en_reg   <= disp_in_range;
                mem_addr_reg <= disp_lin;
            end else if (host_fire) begin
                // Out-of-range host writes still complete the handshake but never touch the RAM.
                mem_en_reg    <= host_in_range;
                mem_we_reg    <= host_in_range;
                mem_addr_reg  <= host_wr_addr;
                mem_wdata_reg <= host_wr_data;
            end

            disp_vld_pipe_reg  <= {disp_vld_pipe_reg[0], disp_ready};
            disp_ok_pipe_reg   <= {disp_ok_pipe_reg[0], disp_ready & disp_in_range};
            disp_rgb_reg       <= disp_ok_pipe_reg[1] ? mem_rdata : '0;
            disp_rgb_valid_reg <= disp_vld_pipe_reg[1];
        end
    end

    assign mem_en         = mem_en_reg;
    assign mem_we         = mem_we_reg;
    assign mem_addr       = mem_addr_reg;
    assign mem_wdata      = mem_wdata_reg;
    assign disp_rgb       = disp_rgb_reg;
    assign disp_rgb_valid = disp_rgb_valid_reg;
    assign frame_start    = frame_start_reg;
    assign starve_err     = starve_err_reg;
    assign addr_err       = addr_err_reg;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: vector table, hand sequences and a randomized run,
// all watched by a cycle-level reference model of the arbiter's external behaviour.
module tb_vga_fb_arbiter;

    localparam int H     = 800;
    localparam int V     = 600;
    localparam int AW    = 19;
    localparam int DW    = 3;
    localparam int SMAX  = 16;
    localparam int PIX   = H * V;
    localparam int RAM_N = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_ready;
    logic [11:0]   disp_x, disp_y;
    logic          frame_lock;
    logic          host_wr_valid;
    logic          host_wr_ready;
    logic [AW-1:0] host_wr_addr;
    logic [DW-1:0] host_wr_data;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = 3'd0;
    logic [DW-1:0] disp_rgb;
    logic          disp_rgb_valid, frame_start, starve_err, addr_err;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .disp_ready(disp_ready), .disp_x(disp_x), .disp_y(disp_y),
        .frame_lock(frame_lock),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .disp_rgb(disp_rgb), .disp_rgb_valid(disp_rgb_valid),
        .frame_start(frame_start), .starve_err(starve_err), .addr_err(addr_err)
    );

    // Power-up picture content; pattern(0) = 3'b101.
    function automatic logic [2:0] pattern(input int a);
        return 3'(a ^ (a >> 3) ^ (a >> 7) ^ 5);
    endfunction

    // Single-port RAM with registered read; stored as an overlay on the power-up picture.
    logic [2:0] ram [0:RAM_N-1] = '{default: 3'd0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata ^ pattern(int'(mem_addr));
            else        mem_rdata     <= ram[mem_addr] ^ pattern(int'(mem_addr));
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int         phase;          // 0 waiting for sync, 1 scanning, 2 vertical blank
    bit         last_px, exp_fs, exp_starve, exp_aerr, exp_en, exp_we;
    int         exp_addr, exp_wd, scnt;
    int         exp_q[$];       // per-cycle display result: valid*8 + rgb
    logic [2:0] img [int];      // pixels the host has written
    bit         m_rdy, m_fire, m_din, m_hin, m_sof;
    int         m_a, m_e;

    function automatic logic [2:0] img_rd(input int a);
        return img.exists(a) ? img[a] : pattern(a);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                phase = 0; last_px = 0; exp_fs = 0; exp_starve = 0; exp_aerr = 0;
                exp_en = 0; exp_we = 0; scnt = 0;
                exp_q.delete();
                for (int i = 0; i < 3; i++) exp_q.push_back(0);
            end else begin
                m_rdy = !disp_ready && (!frame_lock || phase == 2);
                chk("host_wr_ready", int'(host_wr_ready), int'(m_rdy));
                if (exp_q.size() >= 3) begin
                    m_e = exp_q.pop_front();
                    chk("disp_rgb_valid", int'(disp_rgb_valid), m_e / 8);
                    chk("disp_rgb", int'(disp_rgb), m_e % 8);
                end
                chk("frame_start", int'(frame_start), int'(exp_fs));
                chk("starve_err", int'(starve_err), int'(exp_starve));
                chk("addr_err", int'(addr_err), int'(exp_aerr));
                chk("mem_en", int'(mem_en), int'(exp_en));
                if (exp_en) begin
                    chk("mem_we", int'(mem_we), int'(exp_we));
                    chk("mem_addr", int'(mem_addr), exp_addr);
                    if (exp_we) chk("mem_wdata", int'(mem_wdata), exp_wd);
                end

                m_din  = (int'(disp_x) < H) && (int'(disp_y) < V);
                m_a    = int'(disp_y) * H + int'(disp_x);
                m_fire = host_wr_valid && m_rdy;
                m_hin  = int'(host_wr_addr) < PIX;
                if (disp_ready) exp_q.push_back(8 + (m_din ? int'(img_rd(m_a)) : 0));
                else            exp_q.push_back(0);

                exp_en = 0; exp_we = 0;
                if (disp_ready) begin
                    exp_en = m_din; exp_addr = m_a;
                end else if (m_fire) begin
                    exp_en = m_hin; exp_we = m_hin;
                    exp_addr = int'(host_wr_addr); exp_wd = int'(host_wr_data);
                    if (m_hin) img[int'(host_wr_addr)] = host_wr_data;
                end
                if ((disp_ready && !m_din) || (m_fire && !m_hin)) exp_aerr = 1;

                if (host_wr_valid && !m_rdy) begin
                    if (scnt < SMAX) scnt++;
                    if (scnt == SMAX) exp_starve = 1;
                end else begin
                    scnt = 0;
                end

                m_sof  = disp_ready && disp_x == 0 && disp_y == 0;
                exp_fs = m_sof;
                if (m_sof) phase = 1;
                else if (phase == 1 && last_px && !disp_ready) phase = 2;
                last_px = disp_ready && int'(disp_x) == H - 1 && int'(disp_y) == V - 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic dr; int x; int y;
        logic hv; int ha; int hd; logic fl;
        logic e_rdy; logic e_en; logic e_we; int e_addr; int e_wd;
    } vec_t;
    vec_t vecs [14];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dr, input int x, input int y, input logic hv,
                         input int ha, input int hd, input logic fl);
        disp_ready    = dr;
        disp_x        = 12'(x);
        disp_y        = 12'(y);
        host_wr_valid = hv;
        host_wr_addr  = AW'(ha);
        host_wr_data  = DW'(hd);
        frame_lock    = fl;
    endtask

    function automatic int pick_x();
        int r;
        r = $urandom_range(0, 19);
        if (r == 19) return 800;
        if (r >= 15) return 799;
        return r % 4;
    endfunction

    function automatic int pick_y();
        int r;
        r = $urandom_range(0, 19);
        if (r == 19) return 600;
        if (r >= 13) return 599;
        return r % 2;
    endfunction

    initial begin
        //         dr  x    y    hv  ha      hd fl  rdy en we addr    wd
        vecs[0]  = '{1, 5,   2,   0, 0,      0, 0,  0,  1, 0, 1605,   0};
        vecs[1]  = '{1, 799, 10,  1, 100,    3, 0,  0,  1, 0, 8799,   0};
        vecs[2]  = '{0, 0,   0,   1, 100,    3, 0,  1,  1, 1, 100,    3};
        vecs[3]  = '{0, 0,   0,   0, 0,      0, 0,  1,  0, 0, 0,      0};
        vecs[4]  = '{1, 0,   600, 0, 0,      0, 0,  0,  0, 0, 0,      0};
        vecs[5]  = '{0, 0,   0,   1, 480000, 7, 0,  1,  0, 0, 0,      0};
        vecs[6]  = '{1, 0,   599, 0, 0,      0, 0,  0,  1, 0, 479200, 0};
        vecs[7]  = '{0, 0,   0,   1, 479999, 6, 0,  1,  1, 1, 479999, 6};
        vecs[8]  = '{0, 0,   0,   1, 300,    1, 1,  0,  0, 0, 0,      0};
        vecs[9]  = '{1, 799, 599, 1, 300,    1, 1,  0,  1, 0, 479999, 0};
        vecs[10] = '{0, 0,   0,   1, 300,    1, 1,  0,  0, 0, 0,      0};
        vecs[11] = '{0, 0,   0,   1, 200,    2, 1,  1,  1, 1, 200,    2};
        vecs[12] = '{1, 0,   0,   0, 0,      0, 1,  0,  1, 0, 0,      0};
        vecs[13] = '{0, 0,   0,   1, 200,    2, 1,  0,  0, 0, 0,      0};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("ready_in_reset", int'(host_wr_ready), 0);
        end
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_en", int'(mem_en), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_disp_rgb_valid", int'(disp_rgb_valid), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_flags", int'({starve_err, addr_err}), 0);
        $display("reset: outputs idle, state waiting for sync");

        // First pixel of a frame reads RAM[0] = 3'b101.
        cyc();
        drive(1, 0, 0, 0, 0, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("first_mem_en", int'(mem_en), 1);
        chk("first_mem_we", int'(mem_we), 0);
        chk("first_mem_addr", int'(mem_addr), 0);
        chk("first_frame_start", int'(frame_start), 1);
        cyc();
        cyc();
        @(negedge clk);
        chk("first_disp_rgb", int'(disp_rgb), 5);
        chk("first_disp_valid", int'(disp_rgb_valid), 1);
        $display("frame start: pixel (0,0) -> rgb %0d valid %0d", disp_rgb, disp_rgb_valid);
        cyc();

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].dr, vecs[i].x, vecs[i].y, vecs[i].hv, vecs[i].ha, vecs[i].hd, vecs[i].fl);
            @(negedge clk);
            chk("vec_ready", int'(host_wr_ready), int'(vecs[i].e_rdy));
            if (i > 0) begin
                chk("vec_mem_en", int'(mem_en), int'(vecs[i-1].e_en));
                if (vecs[i-1].e_en) begin
                    chk("vec_mem_we", int'(mem_we), int'(vecs[i-1].e_we));
                    chk("vec_mem_addr", int'(mem_addr), vecs[i-1].e_addr);
                    if (vecs[i-1].e_we) chk("vec_mem_wdata", int'(mem_wdata), vecs[i-1].e_wd);
                end
            end
            $display("vec %0d: dr=%0d x=%0d y=%0d hv=%0d fl=%0d -> ready=%0d", i, vecs[i].dr,
                     vecs[i].x, vecs[i].y, vecs[i].hv, vecs[i].fl, host_wr_ready);
            cyc();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("vec_mem_en", int'(mem_en), int'(vecs[13].e_en));
        cyc();

        // Host blocked by frame lock during scan: flag after exactly SMAX blocked cycles.
        drive(0, 0, 0, 1, 50, 1, 1);
        repeat (SMAX - 1) cyc();
        @(negedge clk);
        chk("starve_before_limit", int'(starve_err), 0);
        cyc();
        @(negedge clk);
        chk("starve_at_limit", int'(starve_err), 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc();
        @(negedge clk);
        chk("starve_sticky", int'(starve_err), 1);
        $display("starvation: starve_err=%0d after %0d blocked cycles", starve_err, SMAX);

        // Randomized traffic; the reference model checks every cycle.
        for (int n = 0; n < 1500; n++) begin
            cyc();
            drive($urandom_range(0, 9) < 6, pick_x(), pick_y(), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 29) == 0) ? PIX + int'($urandom_range(0, 100))
                                               : pick_y() * H + pick_x(),
                  int'($urandom_range(0, 7)), $urandom_range(0, 9) < 3);
        end
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        $display("random: 1500 cycles of mixed display/host traffic");

        // Out-of-range display request after a fresh reset.
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(1, 800, 3, 0, 0, 0, 0);
        @(negedge clk);
        chk("oor_addr_err_before", int'(addr_err), 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("oor_mem_en", int'(mem_en), 0);
        chk("oor_addr_err", int'(addr_err), 1);
        cyc();
        cyc();
        @(negedge clk);
        chk("oor_disp_rgb", int'(disp_rgb), 0);
        chk("oor_disp_valid", int'(disp_rgb_valid), 1);
        $display("display x=800: rgb=%0d valid=%0d addr_err=%0d", disp_rgb, disp_rgb_valid, addr_err);

        // Reset while a host write is on the RAM bus.
        cyc();
        drive(0, 0, 0, 1, 123, 4, 0);
        @(negedge clk);
        chk("inflight_ready", int'(host_wr_ready), 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("inflight_mem_we", int'(mem_en & mem_we), 1);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_mem_en", int'(mem_en), 0);
        chk("post_rst_addr_err", int'(addr_err), 0);
        chk("post_rst_starve_err", int'(starve_err), 0);
        chk("post_rst_disp_valid", int'(disp_rgb_valid), 0);
        $display("reset mid-write: mem_en=%0d addr_err=%0d starve_err=%0d", mem_en, addr_err, starve_err);
        repeat (4) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
